// File: rtl/byte_stuffer_if.sv
// Handshake bundle between the bit-packer, the byte stuffer and the byte sink.
// The master modport is the environment side; the slave modport is the stuffer.
interface byte_stuffer_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;
    logic        busy;

    modport master (
        output in_data, in_valid, in_last, in_bytes, out_ready,
        input  in_ready, out_byte, out_valid, out_last, overflow, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, out_ready,
        output in_ready, out_byte, out_valid, out_last, overflow, busy
    );
endinterface

// File: rtl/byte_stuffer.sv
// JPEG byte stuffer: buffers packed 32-bit words, emits them MSB byte first,
// inserts 0x00 after every 0xFF data byte and appends the EOI marker after the last word.
module byte_stuffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          nrst,
    byte_stuffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BYTE  = 3'd1;
    localparam logic [2:0] S_STUFF = 3'd2;
    localparam logic [2:0] S_MRKFF = 3'd3;
    localparam logic [2:0] S_MRKD9 = 3'd4;

    // FIFO entry layout: [35] last flag, [34:32] byte count, [31:0] data
    logic [35:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic [2:0]    r_state;
    logic [31:0]   r_word;
    logic [2:0]    r_nbytes;
    logic          r_last;
    logic [1:0]    r_idx;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_fire;
    logic          w_outValid;
    logic          w_atEnd;
    logic          w_idxInc;
    logic          w_endOfWord;
    logic [2:0]    w_nextState;
    logic [2:0]    w_inBytes;
    logic [7:0]    w_curByte;
    logic [7:0]    w_outByte;
    logic [35:0]   w_head;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_outValid = (r_state != S_IDLE);
    assign w_fire     = w_outValid & bus.out_ready;
    assign w_atEnd    = ({1'b0, r_idx} == (r_nbytes - 3'd1));
    assign w_head     = r_mem[r_rdPtr];
    assign w_push     = bus.in_valid & (~w_full | w_pop);

    // Non-final words always carry four bytes; out-of-range counts are treated as four.
    always_comb begin
        w_inBytes = 3'd4;
        if (bus.in_last && bus.in_bytes != 3'd0 && bus.in_bytes <= 3'd4) begin
            w_inBytes = bus.in_bytes;
        end
    end

    always_comb begin
        w_curByte = r_word[31:24];
        case (r_idx)
            2'd0: w_curByte = r_word[31:24];
            2'd1: w_curByte = r_word[23:16];
            2'd2: w_curByte = r_word[15:8];
            2'd3: w_curByte = r_word[7:0];
            default: w_curByte = r_word[31:24];
        endcase
    end

    always_comb begin
        w_outByte = 8'h00;
        case (r_state)
            S_BYTE:  w_outByte = w_curByte;
            S_STUFF: w_outByte = 8'h00;
            S_MRKFF: w_outByte = 8'hFF;
            S_MRKD9: w_outByte = 8'hD9;
            default: w_outByte = 8'h00;
        endcase
    end

    // State only moves on a handshake, which keeps the output stable while stalled.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_idxInc    = 1'b0;
        w_endOfWord = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = S_BYTE;
                end
            end
            S_BYTE: begin
                if (w_fire) begin
                    if (w_curByte == 8'hFF) begin
                        w_nextState = S_STUFF;
                    end else if (!w_atEnd) begin
                        w_idxInc = 1'b1;
                    end else begin
                        w_endOfWord = 1'b1;
                    end
                end
            end
            S_STUFF: begin
                if (w_fire) begin
                    if (!w_atEnd) begin
                        w_idxInc    = 1'b1;
                        w_nextState = S_BYTE;
                    end else begin
                        w_endOfWord = 1'b1;
                    end
                end
            end
            S_MRKFF: begin
                if (w_fire) begin
                    w_nextState = S_MRKD9;
                end
            end
            S_MRKD9: begin
                if (w_fire) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = S_BYTE;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase

        // Chaining straight into the next queued word avoids a bubble between words.
        if (w_endOfWord) begin
            if (r_last) begin
                w_nextState = S_MRKFF;
            end else if (!w_empty) begin
                w_pop       = 1'b1;
                w_nextState = S_BYTE;
            end else begin
                w_nextState = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {bus.in_last, w_inBytes, bus.in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (bus.in_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_word   <= '0;
            r_nbytes <= 3'd4;
            r_last   <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_pop) begin
                r_word   <= w_head[31:0];
                r_nbytes <= w_head[34:32];
                r_last   <= w_head[35];
                r_idx    <= '0;
            end else if (w_idxInc) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign bus.out_byte  = w_outByte;
    assign bus.out_valid = w_outValid;
    assign bus.out_last  = (r_state == S_MRKD9);
    assign bus.in_ready  = ~w_full;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = ~w_empty | (r_state != S_IDLE);

endmodule

// File: tb/tb_byte_stuffer.sv
// Scoreboard bench for byte_stuffer: directed words push hand-computed bytes into a queue
// that a negedge monitor pops on every output handshake.
module tb_byte_stuffer;

    logic clk;
    logic nrst;
    int   checkCount;
    int   passCount;
    logic [8:0] expQ [$];
    logic       hadStall;
    logic [8:0] stallVal;

    byte_stuffer_if bif ();

    byte_stuffer #(.DEPTH(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic last, input logic [2:0] nb);
        bif.in_data  = data;
        bif.in_last  = last;
        bif.in_bytes = nb;
        bif.in_valid = 1'b1;
        tick();
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic expectBytes(input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = word[31 - 8*i -: 8];
            expQ.push_back({1'b0, b});
        end
    endtask

    task automatic drain(input string name, input bit toggle);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            if (toggle) bif.out_ready = ~bif.out_ready;
            tick();
            n++;
        end
        checkOutput(name, expQ.size(), 0);
        bif.out_ready = 1'b1;
    endtask

    // Expects n valid bytes on n consecutive cycles once the first one appears.
    task automatic waitRun(input string name, input int n);
        int w;
        w = 0;
        @(negedge clk);
        while (!bif.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput({name, "Start"}, bif.out_valid, 1);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            checkOutput({name, "Run"}, bif.out_valid, 1);
        end
    endtask

    always @(negedge clk) begin
        if (nrst && bif.out_valid) begin
            if (hadStall) begin
                checkOutput("heldByte", {23'd0, bif.out_last, bif.out_byte}, {23'd0, stallVal});
            end
            if (bif.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedByte", {23'd0, bif.out_last, bif.out_byte}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("outByte", {23'd0, bif.out_last, bif.out_byte}, {23'd0, expQ.pop_front()});
                end
            end
            hadStall = !bif.out_ready;
            stallVal = {bif.out_last, bif.out_byte};
        end else begin
            hadStall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount    = 0;
        passCount     = 0;
        hadStall      = 1'b0;
        stallVal      = '0;
        nrst          = 1'b0;
        bif.in_data   = '0;
        bif.in_valid  = 1'b0;
        bif.in_last   = 1'b0;
        bif.in_bytes  = '0;
        bif.out_ready = 1'b1;
        tick();
        tick();
        checkOutput("rstValid", bif.out_valid, 0);
        checkOutput("rstLast", bif.out_last, 0);
        checkOutput("rstBusy", bif.busy, 0);
        checkOutput("rstOverflow", bif.overflow, 0);
        checkOutput("rstInReady", bif.in_ready, 1);
        nrst = 1'b1;
        tick();

        $display("[TB] test 1: single word with one 0xFF");
        expectBytes(32'h12FF0000, 2);
        expQ.push_back(9'h000);
        expectBytes(32'h34560000, 2);
        applyStimulus(32'h12FF3456, 1'b0, 3'd0);
        waitRun("t1", 5);
        drain("t1Drain", 1'b0);
        checkOutput("t1BusyIdle", bif.busy, 0);

        $display("[TB] test 2: last word, two bytes, EOI marker");
        expQ.push_back(9'h0FF); expQ.push_back(9'h000);
        expQ.push_back(9'h0FF); expQ.push_back(9'h000);
        expQ.push_back(9'h0FF); expQ.push_back(9'h1D9);
        applyStimulus(32'hFFFF0000, 1'b1, 3'd2);
        drain("t2Drain", 1'b0);
        checkOutput("t2BusyIdle", bif.busy, 0);
        checkOutput("t2LastLow", bif.out_last, 0);

        $display("[TB] test 3: alternating out_ready");
        expectBytes(32'h12FF0000, 2);
        expQ.push_back(9'h000);
        expectBytes(32'h34560000, 2);
        applyStimulus(32'h12FF3456, 1'b0, 3'd0);
        drain("t3Drain", 1'b1);

        $display("[TB] test 4: fill FIFO while stalled");
        bif.out_ready = 1'b0;
        expectBytes(32'h01020304, 4);
        expectBytes(32'h05060708, 4);
        expectBytes(32'h090A0B0C, 4);
        expectBytes(32'h0D0E0F10, 4);
        expectBytes(32'h11121314, 4);
        applyStimulus(32'h01020304, 1'b0, 3'd0);
        applyStimulus(32'h05060708, 1'b0, 3'd0);
        applyStimulus(32'h090A0B0C, 1'b0, 3'd0);
        applyStimulus(32'h0D0E0F10, 1'b0, 3'd0);
        checkOutput("t4InReadyNotFull", bif.in_ready, 1);
        checkOutput("t4NoOverflowYet", bif.overflow, 0);
        applyStimulus(32'h11121314, 1'b0, 3'd0);
        checkOutput("t4InReadyFull", bif.in_ready, 0);
        applyStimulus(32'hEEEEEEEE, 1'b0, 3'd0);
        checkOutput("t4Overflow", bif.overflow, 1);
        bif.out_ready = 1'b1;
        drain("t4Drain", 1'b0);
        tick();
        checkOutput("t4OverflowSticky", bif.overflow, 1);
        checkOutput("t4BusyIdle", bif.busy, 0);

        $display("[TB] test 5: reset while in STUFF");
        bif.out_ready = 1'b0;
        expQ.push_back(9'h011);
        expQ.push_back(9'h0FF);
        applyStimulus(32'h11FF2233, 1'b0, 3'd0);
        applyStimulus(32'h44556677, 1'b0, 3'd0);
        applyStimulus(32'h8899AABB, 1'b0, 3'd0);
        bif.out_ready = 1'b1;
        tick();
        tick();
        bif.out_ready = 1'b0;
        checkOutput("t5InStuff", {23'd0, bif.out_valid, bif.out_byte}, 32'h100);
        checkOutput("t5ScoreEmpty", expQ.size(), 0);
        nrst = 1'b0;
        tick();
        checkOutput("t5RstValid", bif.out_valid, 0);
        checkOutput("t5RstBusy", bif.busy, 0);
        checkOutput("t5RstOverflow", bif.overflow, 0);
        nrst = 1'b1;
        bif.out_ready = 1'b1;
        tick();
        expectBytes(32'h0A0B0C0D, 4);
        applyStimulus(32'h0A0B0C0D, 1'b0, 3'd0);
        drain("t5Drain", 1'b0);

        $display("[TB] test 6: back-to-back words, no bubble");
        expectBytes(32'h01020304, 4);
        expectBytes(32'h05060708, 4);
        applyStimulus(32'h01020304, 1'b0, 3'd0);
        applyStimulus(32'h05060708, 1'b0, 3'd0);
        waitRun("t6", 8);
        drain("t6Drain", 1'b0);

        $display("[TB] test 7: last word with in_bytes=0 treated as 4");
        expectBytes(32'h0102FF00, 3);
        expQ.push_back(9'h000);
        expQ.push_back(9'h004);
        expQ.push_back(9'h0FF);
        expQ.push_back(9'h1D9);
        applyStimulus(32'h0102FF04, 1'b1, 3'd0);
        drain("t7Drain", 1'b0);
        checkOutput("t7BusyIdle", bif.busy, 0);

        tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
